cdc_hs_tx: RTL and testbench

CDC_HS_TX -- requirements
Module: cdc_hs_tx

---
 rtl/cdc_hs_tx_pkg.sv | 13 +
 rtl/cdc_hs_tx_sync.sv | 35 +++
 rtl/cdc_hs_tx.sv | 100 ++++++++++
 tb/tb_cdc_hs_tx.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_tx_pkg.sv
// Shared CDC handshake definitions.
// Used by the four-phase transmitter and its matching receiver.
package cdc_hs_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } cdc_state_e;

  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/cdc_hs_tx_sync.sv
// Multi-flop single-bit synchronizer.
// Exposes the final stage and the stage feeding it.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic q_pre_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  generate
    if (STAGES < 2) begin : g_bad
      $error("cdc_sync_bit needs at least two stages");
    end
  endgenerate

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  // q_pre_o is the value q_o takes on the next edge.
  assign q_o     = sync_q[STAGES-1];
  assign q_pre_o = sync_q[STAGES-2];

endmodule

// File: rtl/cdc_hs_tx.sv
// Four-phase handshake transmitter: holds a word and
// raises req_o until the synchronized ack completes.
module cdc_hs_tx
  import cdc_hs_tx_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              req_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ack_i,
  output logic              busy,
  output logic              done,
  output logic              err
);

  cdc_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ack_s;
  logic              ack_s_nxt;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk     (clk),
    .rst     (rst),
    .d_i     (ack_i),
    .q_o     (ack_s),
    .q_pre_o (ack_s_nxt)
  );

  assign in_ready = (state_q == IDLE) && !ack_s;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (!ack_s && ack_s_nxt) err_d = 1'b1;
        if (in_valid && in_ready) begin
          data_d  = in_data;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = REL;
        end
      end
      REL: begin
        // Leave on the edge where ack_s falls so the next
        // accept lines up with the done pulse.
        if (!ack_s_nxt) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_o  = req_q;
  assign data_o = data_q;
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Bench for cdc_hs_tx: cycle table for one transfer,
// scoreboarded back-to-back, slow, random and error cases.
module tb_cdc_hs_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        req_o;
  logic [31:0] data_o;
  logic        ack_i;
  logic        busy;
  logic        done;
  logic        err;

  logic        mirror;
  logic        ack_drv;

  assign ack_i = mirror ? req_o : ack_drv;

  always #5 clk = ~clk;

  cdc_hs_tx #(
    .DATA_W      (32),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .req_o    (req_o),
    .data_o   (data_o),
    .ack_i    (ack_i),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          acc_at = 0;
  logic        acc = 1'b0;
  logic        req_prev = 1'b0;
  logic [31:0] cur = '0;
  logic [31:0] sbq[$];

  typedef struct {
    logic        vld;
    logic [31:0] dat;
    logic        req;
    logic        rdy;
    logic        dn;
    logic        bsy;
    logic [31:0] dout;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d got=timeout want=event", nm, cyc);
  endtask

  // Scoreboard observes mid-cycle, then advances one clock.
  task automatic tick();
    @(negedge clk);
    acc = in_valid && in_ready && !rst;
    if (rst) begin
      sbq.delete();
    end else begin
      if (acc) begin
        sbq.push_back(in_data);
        acc_at = cyc;
      end
      if (req_o && !req_prev) begin
        if (sbq.size() == 0) begin
          fail("sb_unexpected_req");
        end else begin
          cur = sbq.pop_front();
          chk("sb_data", data_o, cur);
        end
      end else if (busy) begin
        chk("data_hold", data_o, cur);
      end
      if (done) done_cnt++;
    end
    req_prev = req_o;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_req(input logic lvl, input int budget,
                          input string nm);
    int n;
    n = 0;
    while (req_o !== lvl && n < budget) begin
      tick();
      n++;
    end
    if (req_o !== lvl) fail(nm);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) fail(nm);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] words[3];
    int          acc_cyc[3];
    int          idx;
    int          d0;
    int          dst;
    int          dcnt;
    int          n;
    logic [31:0] rw[8];

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    mirror   = 1'b1;
    ack_drv  = 1'b0;

    tbl[0] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[5] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[6] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[7] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};

    do_reset(3);
    chk("rst_req", req_o, 1'b0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", in_ready, 1'b1);

    // Single transfer, destination acks with zero delay.
    for (int i = 0; i < 8; i++) begin
      in_valid = tbl[i].vld;
      in_data  = tbl[i].dat;
      chk($sformatf("t1_req_c%0d", i), req_o, tbl[i].req);
      chk($sformatf("t1_rdy_c%0d", i), in_ready, tbl[i].rdy);
      chk($sformatf("t1_done_c%0d", i), done, tbl[i].dn);
      chk($sformatf("t1_busy_c%0d", i), busy, tbl[i].bsy);
      chk($sformatf("t1_data_c%0d", i), data_o, tbl[i].dout);
      tick();
    end
    in_valid = 1'b0;

    // Back-to-back with in_valid held high.
    words[0] = 32'h1;
    words[1] = 32'h2;
    words[2] = 32'h3;
    idx      = 0;
    d0       = done_cnt;
    in_valid = 1'b1;
    in_data  = words[0];
    n        = 0;
    while (idx < 3 && n < 60) begin
      tick();
      n++;
      if (acc) begin
        acc_cyc[idx] = acc_at;
        idx++;
        in_valid = (idx < 3);
        in_data  = (idx < 3) ? words[idx] : 32'h0;
      end
    end
    if (idx != 3) fail("b2b_accepts");
    else begin
      chk("b2b_period1", acc_cyc[1] - acc_cyc[0], 6);
      chk("b2b_period2", acc_cyc[2] - acc_cyc[1], 6);
    end
    wait_idle(20, "b2b_idle");
    tick();
    chk("b2b_done_cnt", done_cnt - d0, 3);
    chk("b2b_sb_empty", sbq.size(), 0);
    chk("b2b_last", data_o, 32'h3);

    // Slow destination.
    mirror   = 1'b0;
    ack_drv  = 1'b0;
    d0       = done_cnt;
    in_valid = 1'b1;
    in_data  = 32'hA5A5_0001;
    tick();
    if (!acc) fail("slow_accept");
    in_valid = 1'b0;
    wait_req(1'b1, 5, "slow_req_rise");
    repeat (20) tick();
    chk("slow_req_held", req_o, 1'b1);
    ack_drv = 1'b1;
    wait_req(1'b0, 10, "slow_req_fall");
    repeat (15) tick();
    chk("slow_busy_held", busy, 1'b1);
    ack_drv = 1'b0;
    wait_idle(10, "slow_idle");
    repeat (2) tick();
    chk("slow_done_once", done_cnt - d0, 1);
    chk("slow_err", err, 1'b0);
    chk("slow_data", data_o, 32'hA5A5_0001);

    // Random ack delays with the scoreboard checking order.
    for (int i = 0; i < 8; i++) rw[i] = $urandom;
    d0       = done_cnt;
    idx      = 0;
    dst      = 0;
    dcnt     = 0;
    in_valid = 1'b1;
    in_data  = rw[0];
    n        = 0;
    while (!(idx == 8 && !busy && dst == 0) && n < 6000) begin
      case (dst)
        0: if (req_o) begin
             dcnt = $urandom_range(0, 50);
             dst  = 1;
           end
        1: if (dcnt == 0) begin
             ack_drv = 1'b1;
             dst     = 2;
           end else dcnt--;
        2: if (!req_o) begin
             dcnt = $urandom_range(0, 50);
             dst  = 3;
           end
        default: if (dcnt == 0) begin
             ack_drv = 1'b0;
             dst     = 0;
           end else dcnt--;
      endcase
      tick();
      n++;
      if (acc) begin
        idx++;
        in_valid = (idx < 8);
        in_data  = (idx < 8) ? rw[idx] : 32'h0;
      end
    end
    if (n >= 6000) fail("rand_budget");
    repeat (2) tick();
    chk("rand_done_cnt", done_cnt - d0, 8);
    chk("rand_sb_empty", sbq.size(), 0);
    chk("rand_err", err, 1'b0);

    // Spurious ack pulse while idle.
    in_valid = 1'b0;
    ack_drv  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k == 5) ack_drv = 1'b0;
      chk($sformatf("sp_rdy_k%0d", k), in_ready,
          (k >= 2 && k <= 6) ? 1'b0 : 1'b1);
      chk($sformatf("sp_err_k%0d", k), err, (k >= 2) ? 1'b1 : 1'b0);
      tick();
    end
    repeat (10) tick();
    chk("sp_err_sticky", err, 1'b1);
    do_reset(1);
    chk("sp_err_cleared", err, 1'b0);

    // Reset in the middle of a handshake.
    in_valid = 1'b1;
    in_data  = 32'h5A5A_1234;
    chk("rm_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("rm_req", req_o, 1'b1);
    ack_drv = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_req_drop", req_o, 1'b0);
    chk("rm_busy", busy, 1'b0);
    chk("rm_data", data_o, 32'h0);
    chk("rm_err0", err, 1'b0);
    repeat (3) tick();
    chk("rm_err_set", err, 1'b1);
    chk("rm_rdy_blocked", in_ready, 1'b0);
    ack_drv = 1'b0;
    repeat (3) tick();
    chk("rm_rdy_back", in_ready, 1'b1);
    chk("rm_err_sticky", err, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
